branch_resolver_predictor: RTL and testbench

//  Fetch-side branch predictor plus resolution feedback path: the return direction of the prediction bit carried

---
 rtl/bp_pkg.sv | 34 +++
 rtl/bp_counter_table.sv | 34 +++
 rtl/branch_resolver_predictor.sv | 110 +++++++++++
 tb/tb_branch_resolver_predictor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - Shared types and helpers for the branch predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;

    // Word-aligned PCs: the two low bits never take part in indexing.
    function automatic logic [31:0] pc_idx(input logic [63:0] pc, input int idx_bits);
        logic [63:0] mask;
        mask = (64'd1 << idx_bits) - 64'd1;
        return 32'((pc >> 2) & mask);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [63:0] pc, input int idx_bits,
                                           input int tag_bits);
        logic [63:0] mask;
        mask = (64'd1 << tag_bits) - 64'd1;
        return 32'((pc >> (idx_bits + 2)) & mask);
    endfunction

    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_e'(c + 2'd1);
        end
        return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// rtl/bp_counter_table.sv - 2-bit saturating counter array, comb read, sync write.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output ctr_e                rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken,
    input  logic                wr_alloc
);

    localparam int ENTRIES = 1 << IDX_BITS;

    ctr_e ctr [ENTRIES];

    assign rd_ctr = ctr[rd_idx];

    // A fresh allocation starts weakly taken instead of stepping the old counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= wr_alloc ? WT : ctr_next(ctr[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolver_predictor.sv
// rtl/branch_resolver_predictor.sv - Fetch predictor with BTB and mispredict flush; BP_STATS_EN adds event counters.
module branch_resolver_predictor
    import bp_pkg::*;
#(
    parameter int DBITS    = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] lk_pc,
    output logic             lk_taken,
    output logic [DBITS-1:0] lk_target,
    input  logic             upd_valid,
    input  logic [DBITS-1:0] upd_pc,
    input  logic             upd_pred,
    input  logic             upd_taken,
    input  logic [DBITS-1:0] upd_target,
    output logic             flush,
    output logic [DBITS-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [IDX_BITS-1:0] lk_idx, upd_idx;
    logic [TAG_BITS-1:0] lk_tag, upd_tag;
    logic                btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
    logic [DBITS-1:0]    btb_target [ENTRIES];
    ctr_e                lk_ctr;
    logic                lk_hit, upd_hit, stale_target, mis;
    logic                ctr_we, ctr_alloc;

    assign lk_idx  = IDX_BITS'(pc_idx(64'(lk_pc), IDX_BITS));
    assign lk_tag  = TAG_BITS'(pc_tag(64'(lk_pc), IDX_BITS, TAG_BITS));
    assign upd_idx = IDX_BITS'(pc_idx(64'(upd_pc), IDX_BITS));
    assign upd_tag = TAG_BITS'(pc_tag(64'(upd_pc), IDX_BITS, TAG_BITS));

    assign lk_hit    = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && (lk_ctr == WT || lk_ctr == ST);
    assign lk_target = lk_taken ? btb_target[lk_idx] : lk_pc + DBITS'(4);

    assign upd_hit      = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    assign stale_target = btb_target[upd_idx] != upd_target;
    assign mis = upd_valid && ((upd_pred != upd_taken) || (upd_taken && upd_pred && stale_target));

    // Not-taken branches that miss never allocate and leave the counter alone.
    assign ctr_we    = upd_valid && (upd_taken || upd_hit);
    assign ctr_alloc = upd_taken && !upd_hit;

    bp_counter_table #(
        .IDX_BITS(IDX_BITS)
    ) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (lk_idx),
        .rd_ctr  (lk_ctr),
        .wr_en   (ctr_we),
        .wr_idx  (upd_idx),
        .wr_taken(upd_taken),
        .wr_alloc(ctr_alloc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= mis;
            if (mis) begin
                redirect_pc <= upd_taken ? upd_target : upd_pc + DBITS'(4);
            end
            if (upd_valid && upd_taken) begin
                btb_valid[upd_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && upd_valid && upd_taken) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= upd_target;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mis) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver_predictor.sv
// tb/tb_branch_resolver_predictor.sv - Directed self-checking bench for branch_resolver_predictor.
module tb_branch_resolver_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lk_pc;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_pred;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolver_predictor dut (
        .clk        (clk),
        .reset      (reset),
        .lk_pc      (lk_pc),
        .lk_taken   (lk_taken),
        .lk_target  (lk_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_pred   (upd_pred),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .flush      (flush),
        .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic pred, input logic taken,
                          input logic [31:0] target);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_pred   = pred;
        upd_taken  = taken;
        upd_target = target;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic chk_lk(input string tag, input logic [31:0] pc, input logic exp_taken,
                          input logic [31:0] exp_target);
        lk_pc = pc;
        #1;
        chk({tag, "_taken"}, 64'(lk_taken), 64'(exp_taken));
        chk({tag, "_target"}, 64'(lk_target), 64'(exp_target));
    endtask

    task automatic chk_fl(input string tag, input logic exp_flush, input logic [31:0] exp_redir);
        chk({tag, "_flush"}, 64'(flush), 64'(exp_flush));
        if (exp_flush) begin
            chk({tag, "_redirect"}, 64'(redirect_pc), 64'(exp_redir));
        end
    endtask

    initial begin
        reset = 1'b0;
        lk_pc = 32'h100;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_pred = 1'b0;
        upd_taken = 1'b0;
        upd_target = '0;
        tick();
        tick();
        reset = 1'b1;

        chk_lk("rst", 32'h100, 1'b0, 32'h104);
        chk_fl("rst", 1'b0, 32'h0);

        // Allocate 0x100 -> 0x200; same-cycle lookup must still see the old state.
        upd_valid = 1'b1; upd_pc = 32'h100; upd_pred = 1'b0; upd_taken = 1'b1; upd_target = 32'h200;
        #1;
        chk("same_cycle_old", 64'(lk_taken), 64'd0);
        tick();
        upd_valid = 1'b0;
        chk_fl("alloc", 1'b1, 32'h200);
        chk_lk("alloc", 32'h100, 1'b1, 32'h200);
        tick();
        chk_fl("alloc_pulse_end", 1'b0, 32'h0);

        // Correct prediction with matching target: WT->ST, no flush.
        do_upd(32'h100, 1'b1, 1'b1, 32'h200);
        chk_fl("hit_ok", 1'b0, 32'h0);
        // Correct direction, stale target.
        do_upd(32'h100, 1'b1, 1'b1, 32'h300);
        chk_fl("stale", 1'b1, 32'h300);
        chk_lk("stale", 32'h100, 1'b1, 32'h300);

        // Not-taken walk: ST->WT->WNT->SNT->SNT->SNT.
        do_upd(32'h100, 1'b1, 1'b0, 32'h0);
        chk_fl("nt1", 1'b1, 32'h104);
        chk_lk("nt1", 32'h100, 1'b1, 32'h300);
        do_upd(32'h100, 1'b1, 1'b0, 32'h0);
        chk_fl("nt2", 1'b1, 32'h104);
        chk_lk("nt2", 32'h100, 1'b0, 32'h104);
        do_upd(32'h100, 1'b0, 1'b0, 32'h0);
        chk_fl("nt3", 1'b0, 32'h0);
        do_upd(32'h100, 1'b0, 1'b0, 32'h0);
        chk_fl("nt4", 1'b0, 32'h0);
        chk_lk("nt4", 32'h100, 1'b0, 32'h104);
        do_upd(32'h100, 1'b0, 1'b0, 32'h0);
        chk_fl("nt5", 1'b0, 32'h0);
        chk_lk("nt5", 32'h100, 1'b0, 32'h104);

        // Saturated at SNT: one taken gives WNT (not taken), a second gives WT.
        do_upd(32'h100, 1'b0, 1'b1, 32'h300);
        chk_fl("sat_t1", 1'b1, 32'h300);
        chk_lk("sat_t1", 32'h100, 1'b0, 32'h104);
        do_upd(32'h100, 1'b0, 1'b1, 32'h300);
        chk_fl("sat_t2", 1'b1, 32'h300);
        chk_lk("sat_t2", 32'h100, 1'b1, 32'h300);

        // Alias 0x200 shares idx 0 with a different tag.
        chk_lk("alias", 32'h200, 1'b0, 32'h204);
        do_upd(32'h200, 1'b0, 1'b0, 32'h0);
        chk_fl("alias_nt", 1'b0, 32'h0);
        chk_lk("alias_keep", 32'h100, 1'b1, 32'h300);

`ifdef BP_STATS_EN
        chk("stat_br", 64'(stat_branches), 64'd11);
        chk("stat_mis", 64'(stat_mispredicts), 64'd6);
`endif

        // Pending flush killed by reset; update during reset discarded.
        do_upd(32'h100, 1'b1, 1'b0, 32'h0);
        chk_fl("pre_rst", 1'b1, 32'h104);
        reset = 1'b0;
        upd_valid = 1'b1; upd_pc = 32'h140; upd_pred = 1'b0; upd_taken = 1'b1; upd_target = 32'h500;
        tick();
        upd_valid = 1'b0;
        reset = 1'b1;
        chk_fl("mid_rst", 1'b0, 32'h0);
        chk_lk("rst_upd", 32'h140, 1'b0, 32'h144);
        chk_lk("rst_clr", 32'h100, 1'b0, 32'h104);
`ifdef BP_STATS_EN
        chk("stat_br_rst", 64'(stat_branches), 64'd0);
        chk("stat_mis_rst", 64'(stat_mispredicts), 64'd0);
`endif
        tick();
        chk_fl("post_rst", 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
